// File: rtl/timer_multi_if.sv
// Control/status bundle for timer_multi: prescaler setup, per-channel strobes,
// period write port and the per-channel pulse/running outputs.
interface timer_multi_if #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESC_W  = 8
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                enable;
    logic [PRESC_W-1:0]  prescale;
    logic [CHANNELS-1:0] start;
    logic [CHANNELS-1:0] stop;
    logic [CHANNELS-1:0] oneshot;
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [WIDTH-1:0]    wr_period;
    logic [CHANNELS-1:0] pulse;
    logic [CHANNELS-1:0] running;

    modport master (
        output enable, prescale, start, stop, oneshot, wr_en, wr_ch, wr_period,
        input  pulse, running
    );

    modport slave (
        input  enable, prescale, start, stop, oneshot, wr_en, wr_ch, wr_period,
        output pulse, running
    );
endinterface

// File: rtl/timer_multi.sv
// Multi-channel programmable timer: CHANNELS independent IDLE/RUN counters
// advanced by one shared prescaler tick, each emitting one-clk registered pulses.
module timer_multi #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESC_W  = 8,
    parameter int unsigned PERIOD   = 1000
) (
    input logic          clk,
    input logic          reset_n,
    timer_multi_if.slave bus
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    logic [PRESC_W-1:0]  presc_cnt, presc_next;
    logic                tick;

    state_t              state       [CHANNELS];
    state_t              state_next  [CHANNELS];
    logic [WIDTH-1:0]    cnt         [CHANNELS];
    logic [WIDTH-1:0]    cnt_next    [CHANNELS];
    logic [WIDTH-1:0]    period      [CHANNELS];
    logic [WIDTH-1:0]    period_next [CHANNELS];
    logic [CHANNELS-1:0] mode, mode_next;
    logic [CHANNELS-1:0] pulse, pulse_next;
    logic [CHANNELS-1:0] running;
    logic [CHANNELS-1:0] wr_hit;

    // ">=" rather than "==" so a prescale lowered beneath the count wraps at once.
    always_comb begin
        tick       = bus.enable && (presc_cnt >= bus.prescale);
        presc_next = presc_cnt;
        if (bus.enable) begin
            presc_next = tick ? '0 : presc_cnt + 1'b1;
        end
    end

    always_comb begin
        wr_hit     = '0;
        mode_next  = mode;
        pulse_next = '0;
        running    = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_next[i]  = state[i];
            cnt_next[i]    = cnt[i];
            period_next[i] = period[i];
            running[i]     = (state[i] == RUN);
            // Out-of-range channel indices match no channel and are dropped.
            wr_hit[i]      = bus.wr_en && (bus.wr_ch == CH_W'(i));

            if (wr_hit[i]) begin
                period_next[i] = bus.wr_period;
                cnt_next[i]    = '0;
            end

            if (bus.enable) begin
                if (bus.stop[i]) begin
                    state_next[i] = IDLE;
                    cnt_next[i]   = '0;
                end else if (bus.start[i]) begin
                    state_next[i] = RUN;
                    cnt_next[i]   = '0;
                    mode_next[i]  = bus.oneshot[i];
                end else if (state[i] == RUN && tick && !wr_hit[i] && period[i] != '0) begin
                    if (cnt[i] < period[i] - 1'b1) begin
                        cnt_next[i] = cnt[i] + 1'b1;
                    end else begin
                        cnt_next[i]   = '0;
                        pulse_next[i] = 1'b1;
                        if (mode[i]) begin
                            state_next[i] = IDLE;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_cnt <= '0;
            mode      <= '0;
            pulse     <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state[i]  <= IDLE;
                cnt[i]    <= '0;
                period[i] <= WIDTH'(PERIOD);
            end
        end else begin
            presc_cnt <= presc_next;
            mode      <= mode_next;
            pulse     <= pulse_next;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state[i]  <= state_next[i];
                cnt[i]    <= cnt_next[i];
                period[i] <= period_next[i];
            end
        end
    end

    assign bus.pulse   = pulse;
    assign bus.running = running;
endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: directed scenarios plus randomized
// traffic checked against a tick-count reference model.
module tb_timer_multi;
    localparam int unsigned W   = 32;
    localparam int unsigned C   = 4;
    localparam int unsigned PW  = 8;
    localparam int unsigned CW  = 2;
    localparam int unsigned PER = 1000;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   pass_cnt = 0;
    int   total    = 0;

    timer_multi_if #(.WIDTH(W), .CHANNELS(C), .PRESC_W(PW)) bus ();

    timer_multi #(
        .WIDTH(W), .CHANNELS(C), .PRESC_W(PW), .PERIOD(PER)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: a channel pulses on a tick whose count since its last
    // (re)start or period write is a positive multiple of its period.
    bit          m_run  [C];
    bit          m_os   [C];
    longint      m_per  [C];
    longint      m_base [C];
    longint      m_ticks;
    longint      m_en_clks;
    logic [C-1:0] m_pulse;

    function automatic logic [C-1:0] m_running();
        logic [C-1:0] v;
        for (int ch = 0; ch < int'(C); ch++) v[ch] = m_run[ch];
        return v;
    endfunction

    task automatic step();
        bit tk;
        bit wr;
        tk = 1'b0;
        if (!reset_n) begin
            m_ticks = 0;
            m_en_clks = 0;
            m_pulse = '0;
            for (int ch = 0; ch < int'(C); ch++) begin
                m_run[ch] = 0; m_os[ch] = 0; m_per[ch] = PER; m_base[ch] = 0;
            end
        end else begin
            if (bus.enable) begin
                tk = (m_en_clks % (longint'(bus.prescale) + 1)) == longint'(bus.prescale);
                m_en_clks++;
                if (tk) m_ticks++;
            end
            for (int ch = 0; ch < int'(C); ch++) begin
                m_pulse[ch] = 1'b0;
                wr = bus.wr_en && (int'(bus.wr_ch) == ch);
                if (wr) begin
                    m_per[ch]  = longint'(bus.wr_period);
                    m_base[ch] = m_ticks;
                end
                if (bus.enable) begin
                    if (bus.stop[ch]) begin
                        m_run[ch] = 0;
                    end else if (bus.start[ch]) begin
                        m_run[ch]  = 1;
                        m_os[ch]   = bus.oneshot[ch];
                        m_base[ch] = m_ticks;
                    end else if (m_run[ch] && tk && !wr && m_per[ch] != 0 &&
                                 ((m_ticks - m_base[ch]) % m_per[ch]) == 0) begin
                        m_pulse[ch] = 1'b1;
                        if (m_os[ch]) m_run[ch] = 0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.start = '0; bus.stop = '0; bus.oneshot = '0;
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_period = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic write_period(input int ch, input logic [W-1:0] val);
        bus.wr_en = 1'b1; bus.wr_ch = CW'(ch); bus.wr_period = val;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        int first [C];
        bus.enable = 1'b1; bus.prescale = '0;
        do_reset();
        write_period(1, 7);
        bus.start = '1; step(); bus.start = '0;
        repeat (300) step();
        reset_n = 1'b0; step(); reset_n = 1'b1;
        total++;
        if (bus.pulse !== '0) $display("FAIL reset_pulse: got %b want 0000", bus.pulse);
        else pass_cnt++;
        total++;
        if (bus.running !== '0) $display("FAIL reset_running: got %b want 0000", bus.running);
        else pass_cnt++;
        bus.start = '1; step(); bus.start = '0;
        for (int ch = 0; ch < int'(C); ch++) first[ch] = -1;
        for (int k = 1; k <= int'(PER) + 5; k++) begin
            step();
            for (int ch = 0; ch < int'(C); ch++)
                if (bus.pulse[ch] && first[ch] < 0) first[ch] = k;
        end
        for (int ch = 0; ch < int'(C); ch++) begin
            total++;
            if (first[ch] != int'(PER))
                $display("FAIL reset_first_pulse ch%0d: got %0d want %0d", ch, first[ch], PER);
            else pass_cnt++;
        end
    endtask

    task automatic test_periodic();
        bus.prescale = '0;
        do_reset();
        write_period(0, 5);
        bus.start[0] = 1'b1; step(); bus.start = '0;
        for (int k = 1; k <= 16; k++) begin
            step();
            total++;
            if (bus.pulse[0] !== ((k % 5) == 0) || bus.running[0] !== 1'b1)
                $display("FAIL periodic k=%0d: pulse=%b running=%b want pulse=%b running=1",
                         k, bus.pulse[0], bus.running[0], (k % 5) == 0);
            else pass_cnt++;
        end
    endtask

    task automatic test_oneshot();
        bus.prescale = 8'd2;
        do_reset();
        write_period(1, 3);
        step();
        bus.start[1] = 1'b1; bus.oneshot[1] = 1'b1; step(); clear_inputs();
        for (int k = 1; k <= 20; k++) begin
            step();
            total++;
            if (bus.pulse[1] !== (k == 9) || bus.running[1] !== (k < 9))
                $display("FAIL oneshot k=%0d: pulse=%b running=%b want pulse=%b running=%b",
                         k, bus.pulse[1], bus.running[1], k == 9, k < 9);
            else pass_cnt++;
        end
    endtask

    task automatic test_collisions();
        bus.prescale = '0;
        do_reset();
        bus.start[2] = 1'b1; bus.stop[2] = 1'b1; step(); clear_inputs();
        total++;
        if (bus.running[2] !== 1'b0) $display("FAIL start_stop_idle: running=%b want 0", bus.running[2]);
        else pass_cnt++;
        bus.start[2] = 1'b1; step(); clear_inputs();
        repeat (3) step();
        bus.start[2] = 1'b1; bus.stop[2] = 1'b1; step(); clear_inputs();
        total++;
        if (bus.running[2] !== 1'b0 || bus.pulse[2] !== 1'b0)
            $display("FAIL start_stop_run: running=%b pulse=%b want 0 0", bus.running[2], bus.pulse[2]);
        else pass_cnt++;
        write_period(3, 4);
        bus.start[3] = 1'b1; step(); clear_inputs();
        repeat (3) step();
        write_period(3, 4);
        total++;
        if (bus.pulse[3] !== 1'b0 || bus.running[3] !== 1'b1)
            $display("FAIL write_on_tick: pulse=%b running=%b want 0 1", bus.pulse[3], bus.running[3]);
        else pass_cnt++;
        for (int k = 5; k <= 8; k++) begin
            step();
            total++;
            if (bus.pulse[3] !== (k == 8))
                $display("FAIL write_restart k=%0d: pulse=%b want %b", k, bus.pulse[3], k == 8);
            else pass_cnt++;
        end
    endtask

    task automatic test_boundaries();
        bus.prescale = '0;
        do_reset();
        write_period(0, 1);
        write_period(1, 0);
        bus.start[1:0] = 2'b11; step(); clear_inputs();
        for (int k = 1; k <= 100; k++) begin
            step();
            total++;
            if (bus.pulse[1:0] !== 2'b01 || bus.running[1:0] !== 2'b11)
                $display("FAIL period_1_0 k=%0d: pulse=%b running=%b want 01 11",
                         k, bus.pulse[1:0], bus.running[1:0]);
            else pass_cnt++;
        end
        bus.prescale = 8'd6;
        do_reset();
        write_period(0, 1);
        bus.start[0] = 1'b1; step(); clear_inputs();
        repeat (2) step();
        bus.prescale = 8'd2;
        for (int k = 1; k <= 7; k++) begin
            step();
            total++;
            if (bus.pulse[0] !== (k == 1 || k == 4 || k == 7))
                $display("FAIL prescale_lowered k=%0d: pulse=%b want %b",
                         k, bus.pulse[0], k == 1 || k == 4 || k == 7);
            else pass_cnt++;
        end
    endtask

    task automatic test_enable();
        bus.prescale = '0;
        do_reset();
        write_period(0, 10);
        bus.start[0] = 1'b1; step(); clear_inputs();
        for (int k = 1; k <= 30; k++) begin
            bus.enable = !(k >= 5 && k <= 11);
            step();
            total++;
            if (bus.pulse[0] !== (k == 17 || k == 27) || bus.running[0] !== 1'b1)
                $display("FAIL enable_shift k=%0d: pulse=%b running=%b want pulse=%b running=1",
                         k, bus.pulse[0], bus.running[0], k == 17 || k == 27);
            else pass_cnt++;
        end
        bus.enable = 1'b1;
    endtask

    task automatic test_concurrent();
        int per [C] = '{3, 4, 5, 7};
        logic [C-1:0] exp;
        bus.prescale = '0;
        do_reset();
        for (int ch = 0; ch < int'(C); ch++) write_period(ch, W'(per[ch]));
        bus.start = '1; step(); clear_inputs();
        for (int k = 1; k <= 60; k++) begin
            step();
            for (int ch = 0; ch < int'(C); ch++) exp[ch] = (k % per[ch]) == 0;
            total++;
            if (bus.pulse !== exp)
                $display("FAIL concurrent k=%0d: pulse=%b want %b", k, bus.pulse, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        bus.prescale = PW'($urandom_range(0, 3));
        bus.enable = 1'b1;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bus.enable = ($urandom_range(0, 9) != 0);
            for (int ch = 0; ch < int'(C); ch++) begin
                bus.start[ch]   = ($urandom_range(0, 15) == 0);
                bus.stop[ch]    = ($urandom_range(0, 23) == 0);
                bus.oneshot[ch] = $urandom_range(0, 1) == 1;
            end
            bus.wr_en     = ($urandom_range(0, 19) == 0);
            bus.wr_ch     = CW'($urandom_range(0, C - 1));
            bus.wr_period = W'($urandom_range(0, 9));
            step();
            total++;
            if (bus.pulse !== m_pulse)
                $display("FAIL random_pulse n=%0d: got %b want %b", n, bus.pulse, m_pulse);
            else pass_cnt++;
            total++;
            if (bus.running !== m_running())
                $display("FAIL random_running n=%0d: got %b want %b", n, bus.running, m_running());
            else pass_cnt++;
        end
        clear_inputs();
        bus.enable = 1'b1;
    endtask

    initial begin
        clear_inputs();
        bus.enable = 1'b1;
        bus.prescale = '0;
        test_reset();
        test_periodic();
        test_oneshot();
        test_collisions();
        test_boundaries();
        test_enable();
        test_concurrent();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
